calculator_stream: RTL and testbench

CALCULATOR_STREAM -- requirements
Module: calculator_stream

---
 rtl/calculator_stream_if.sv | 43 ++++
 rtl/calculator_stream.sv | 145 ++++++++++++++
 tb/tb_calculator_stream.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calculator_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : calculator_stream_if
//  Purpose  : Bundles the instruction-load and result-stream handshakes of
//             calculator_stream.
//  Ports    : master - instruction producer / result consumer
//             slave  - calculator core
//             din/din_valid/din_ready  instruction load handshake
//             start                    early batch launch request
//             result/neg/res_index     result payload
//             res_valid/res_ready      result handshake
//             count/busy               batch status
//  Revision : 1.0 - initial release
// ============================================================================
interface calculator_stream_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [2*DATA_W+1:0] din;
   logic                din_valid;
   logic                din_ready;
   logic                start;
   logic [2*DATA_W-1:0] result;
   logic                neg;
   logic [ADDR_W-1:0]   res_index;
   logic                res_valid;
   logic                res_ready;
   logic [ADDR_W:0]     count;
   logic                busy;

   modport master (
      output din, din_valid, start, res_ready,
      input  din_ready, result, neg, res_index, res_valid, count, busy
   );

   modport slave (
      input  din, din_valid, start, res_ready,
      output din_ready, result, neg, res_index, res_valid, count, busy
   );
endinterface
`default_nettype wire

// File: rtl/calculator_stream.sv
`default_nettype none
// ============================================================================
//  Module   : calculator_stream
//  Purpose  : Buffers a batch of up to DEPTH two-operand instructions, then
//             streams one ALU result per slot in slot order.
//  Ports    : clk   - clock, all state changes on rising edge
//             reset - synchronous active-high reset
//             bus   - calculator_stream_if.slave (load, start, result
//                     stream and status signals)
//  Revision : 1.0 - initial release
// ============================================================================
module calculator_stream #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  wire logic             clk,
   input  wire logic             reset,
   calculator_stream_if.slave    bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int INS_W  = 2*DATA_W + 2;
   localparam int RES_W  = 2*DATA_W;
   localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   state_t              state_q,     state_d;
   logic [ADDR_W:0]     count_q,     count_d;
   logic [ADDR_W:0]     exec_idx_q,  exec_idx_d;
   logic                res_valid_q, res_valid_d;
   logic [RES_W-1:0]    result_q,    result_d;
   logic                neg_q,       neg_d;
   logic [ADDR_W-1:0]   res_index_q, res_index_d;

   // Instruction buffer: never cleared, each batch overwrites from slot 0.
   logic [INS_W-1:0]    buf_mem [DEPTH];

   logic                w_din_ready;
   logic                w_wr_en;
   logic                w_issue;
   logic [INS_W-1:0]    w_ins;
   logic [RES_W-1:0]    w_a, w_b;
   logic [RES_W-1:0]    w_alu_res;
   logic                w_alu_neg;

   assign w_din_ready = (state_q == ST_LOAD) && (count_q < C_FULL);
   assign w_wr_en     = w_din_ready && bus.din_valid;

   // ALU on the slot currently pointed at by the exec index.
   assign w_ins = buf_mem[exec_idx_q[ADDR_W-1:0]];
   assign w_a   = {{DATA_W{1'b0}}, w_ins[2*DATA_W-1:DATA_W]};
   assign w_b   = {{DATA_W{1'b0}}, w_ins[DATA_W-1:0]};

   always_comb begin
      w_alu_res = '0;
      w_alu_neg = 1'b0;
      case (w_ins[INS_W-1:INS_W-2])
         2'b00: w_alu_res = w_a + w_b;
         2'b01: begin
            w_alu_neg = (w_a < w_b);
            w_alu_res = w_alu_neg ? (w_b - w_a) : (w_a - w_b);
         end
         2'b10: w_alu_res = w_a * w_b;
         default: w_alu_res = w_a & w_b;
      endcase
   end

   assign w_issue = (exec_idx_q < count_q) && (!res_valid_q || bus.res_ready);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      exec_idx_d  = exec_idx_q;
      res_valid_d = res_valid_q;
      result_d    = result_q;
      neg_d       = neg_q;
      res_index_d = res_index_q;
      case (state_q)
         ST_LOAD: begin
            if (w_wr_en) begin
               count_d = count_q + 1'b1;
            end
            // count_d != 0 covers both an already-loaded entry and a
            // same-edge write, so start never launches an empty batch.
            if ((count_d == C_FULL) || (bus.start && (count_d != '0))) begin
               state_d    = ST_EXEC;
               exec_idx_d = '0;
            end
         end
         default: begin
            if (w_issue) begin
               result_d    = w_alu_res;
               neg_d       = w_alu_neg;
               res_index_d = exec_idx_q[ADDR_W-1:0];
               res_valid_d = 1'b1;
               exec_idx_d  = exec_idx_q + 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
               // Final handshake: no slot left to issue.
               res_valid_d = 1'b0;
               state_d     = ST_LOAD;
               count_d     = '0;
               exec_idx_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_LOAD;
         count_q     <= '0;
         exec_idx_q  <= '0;
         res_valid_q <= 1'b0;
         result_q    <= '0;
         neg_q       <= 1'b0;
         res_index_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         exec_idx_q  <= exec_idx_d;
         res_valid_q <= res_valid_d;
         result_q    <= result_d;
         neg_q       <= neg_d;
         res_index_q <= res_index_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) begin
         buf_mem[count_q[ADDR_W-1:0]] <= bus.din;
      end
   end

   assign bus.din_ready = w_din_ready;
   assign bus.busy      = (state_q == ST_EXEC);
   assign bus.count     = count_q;
   assign bus.res_valid = res_valid_q;
   assign bus.result    = result_q;
   assign bus.neg       = neg_q;
   assign bus.res_index = res_index_q;
endmodule
`default_nettype wire

// File: tb/tb_calculator_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calculator_stream
//  Purpose  : Self-checking bench for calculator_stream. A queue-based batch
//             model predicts every output each cycle; a few literal results
//             pin the model's arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calculator_stream;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LIT_RES [5] = '{32'h012C, 4, 4, 32'hFE01, 32'h0030};
   localparam int LIT_NEG [5] = '{0, 1, 0, 0, 0};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   calculator_stream_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

   calculator_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- model / compare state (owned by compare process)
   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;
   logic [2*DATA_W+1:0] batch [$];
   int  exp_res [$];
   int  exp_neg [$];
   int  exp_idx [$];
   bit  m_busy = 1'b0;
   bit  m_valid = 1'b0;
   int  m_result = 0, m_neg = 0, m_idx = 0;
   int  cyc = 0;
   int  n1 = 0, first1 = 0, last1 = 0;
   int  n3 = 0;
   bit  p1_done = 1'b0, p3_done = 1'b0, tmo_seen = 1'b0;

   // ---------------- stimulus-owned flags
   int  phase = 0;
   bit  tmo = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic void model_alu(input logic [2*DATA_W+1:0] ins,
                                     output int r, output int n);
      int a, b;
      a = int'(ins[2*DATA_W-1:DATA_W]);
      b = int'(ins[DATA_W-1:0]);
      n = 0;
      case (ins[2*DATA_W+1:2*DATA_W])
         2'd0: r = a + b;
         2'd1: begin n = (a < b) ? 1 : 0; r = (a < b) ? b - a : a - b; end
         2'd2: r = a * b;
         default: r = a & b;
      endcase
   endfunction

   // ---------------- compare process
   always @(negedge clk) begin
      int k, r, n;
      cyc++;
      if (model_on) begin
         chk("din_ready", int'(bus.din_ready), (!m_busy && batch.size() < DEPTH) ? 1 : 0);
         chk("busy", int'(bus.busy), int'(m_busy));
         chk("count", int'(bus.count), batch.size());
         chk("res_valid", int'(bus.res_valid), int'(m_valid));
         chk("result", int'(bus.result), m_result);
         chk("neg", int'(bus.neg), m_neg);
         chk("res_index", int'(bus.res_index), m_idx);
      end
      if (phase == 1 && bus.res_valid) begin
         k = int'(bus.res_index);
         if (n1 == 0) first1 = cyc;
         last1 = cyc;
         n1++;
         if (k < 5) begin
            chk("lit_result", int'(bus.result), LIT_RES[k]);
            chk("lit_neg", int'(bus.neg), LIT_NEG[k]);
         end
      end
      if (phase >= 2 && !p1_done) begin
         chk("p1_results", n1, 16);
         chk("p1_span", last1 - first1, 15);
         p1_done = 1'b1;
      end
      if (phase == 3 && bus.res_valid && bus.res_ready) n3++;
      if (phase >= 4 && !p3_done) begin
         chk("p3_results", n3, 3);
         p3_done = 1'b1;
      end
      if (tmo && !tmo_seen) begin
         chk("timeout", 1, 0);
         tmo_seen = 1'b1;
      end

      // advance the model across the coming rising edge
      if (reset) begin
         batch.delete(); exp_res.delete(); exp_neg.delete(); exp_idx.delete();
         m_busy = 1'b0; m_valid = 1'b0;
         m_result = 0; m_neg = 0; m_idx = 0;
         model_on = 1'b1;
      end else if (model_on) begin
         if (!m_busy) begin
            if (bus.din_valid && batch.size() < DEPTH) batch.push_back(bus.din);
            if (batch.size() == DEPTH || (bus.start && batch.size() >= 1)) begin
               m_busy = 1'b1;
               foreach (batch[i]) begin
                  model_alu(batch[i], r, n);
                  exp_res.push_back(r);
                  exp_neg.push_back(n);
                  exp_idx.push_back(i);
               end
            end
         end else if (!m_valid || bus.res_ready) begin
            if (exp_res.size() > 0) begin
               m_result = exp_res.pop_front();
               m_neg    = exp_neg.pop_front();
               m_idx    = exp_idx.pop_front();
               m_valid  = 1'b1;
            end else begin
               m_valid = 1'b0;
               m_busy  = 1'b0;
               batch.delete();
            end
         end
      end
   end

   // ---------------- stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         step();
         n++;
      end
      if (bus.busy) tmo = 1'b1;
   endtask

   task automatic load(input int num);
      for (int i = 0; i < num; i++) begin
         bus.din_valid = 1'b1;
         bus.din = (2*DATA_W+2)'($urandom);
         step();
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      logic [2*DATA_W+1:0] fixed [5];
      fixed[0] = {2'b00, 8'd200, 8'd100};
      fixed[1] = {2'b01, 8'd5,   8'd9};
      fixed[2] = {2'b01, 8'd9,   8'd5};
      fixed[3] = {2'b10, 8'd255, 8'd255};
      fixed[4] = {2'b11, 8'hF0,  8'h3C};

      reset = 1'b1;
      bus.din = '0; bus.din_valid = 1'b0; bus.start = 1'b0; bus.res_ready = 1'b1;
      step(); step();
      reset = 1'b0;
      step();

      // full batch, known first slots, consumer always ready
      phase = 1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.din_valid = 1'b1;
         bus.din = (i < 5) ? fixed[i] : (2*DATA_W+2)'($urandom);
         step();
      end
      bus.din_valid = 1'b1;          // dropped: buffer is busy
      step();
      bus.din_valid = 1'b0;
      wait_idle(60);
      phase = 2;
      step();

      // start with an empty buffer is ignored
      bus.start = 1'b1; step(); step(); bus.start = 1'b0;

      // three-entry batch launched by start
      phase = 3;
      load(3);
      pulse_start();
      wait_idle(30);
      step();
      phase = 4;
      step();

      // consumer stalls 5 cycles mid-batch
      load(6);
      pulse_start();
      step(); step(); step();
      bus.res_ready = 1'b0;
      repeat (5) step();
      bus.res_ready = 1'b1;
      wait_idle(30);
      step();

      // start on the same edge as the first write
      bus.din_valid = 1'b1; bus.din = (2*DATA_W+2)'($urandom); bus.start = 1'b1;
      step();
      bus.din_valid = 1'b0; bus.start = 1'b0;
      wait_idle(30);
      step();

      // reset during EXEC after two results have been consumed
      load(6);
      pulse_start();
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step(); step();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bus.din_valid = ($urandom_range(0, 1) == 1);
         bus.din       = (2*DATA_W+2)'($urandom);
         bus.start     = ($urandom_range(0, 7) == 0);
         bus.res_ready = ($urandom_range(0, 3) != 0);
         reset         = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0; bus.din_valid = 1'b0; bus.start = 1'b0; bus.res_ready = 1'b1;
      wait_idle(60);
      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
